kernel_share_arbiter: RTL and testbench
=======================================

KERNEL_SHARE_ARBITER -- requirements
Module: kernel_share_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 10, kernel argument/result width.
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter DEPTH, default 4, max kernel transactions in flight (power of 2, 2..16).
REQ-004 SHALL have port clk  in  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_data  in  N_REQ*DATA_W, req_valid  in  N_REQ, req_ready  out  N_REQ  requester argument channels; slice i belongs to requester i.
REQ-007 SHALL have ports rsp_data  out  DATA_W, rsp_valid  out  N_REQ, rsp_ready  in  N_REQ  response channels; data shared, valid/ready per requester.
REQ-008 SHALL have ports k_arg0  out  DATA_W, k_arg0_valid  out  1, k_arg0_ready  in  1  the kernel argument channel.
REQ-009 SHALL have ports k_out0  in  DATA_W, k_out0_valid  in  1, k_out0_ready  out  1  the kernel result channel.
REQ-010 SHALL have ports inflight  out  clog2(DEPTH+1)  outstanding count; err  out  1  sticky protocol error.

Function
REQ-011 SHALL share one in-order kernel among N_REQ requesters; transfer on any channel = valid & ready in the same cycle.
REQ-012 SHALL keep a tag FIFO (DEPTH entries, clog2(N_REQ) bits) of the requester index per issued argument; push on k_arg0 transfer, pop on k_out0 transfer.
REQ-013 SHALL implement FSM {IDLE, LOCK}.
REQ-014 IDLE: if fifo not full and any req_valid, grant = first valid index searching upward from rr_ptr with wrap N_REQ-1 -> 0; k_arg0_valid=1, k_arg0=req_data[grant] in the same cycle (zero-cycle issue).
REQ-015 IDLE with grant and k_arg0_ready=1: transfer, stay IDLE; with k_arg0_ready=0: register grant, go LOCK.
REQ-016 LOCK: k_arg0_valid=1, k_arg0=req_data[locked grant]; other requesters ignored; on k_arg0_ready=1 transfer and return IDLE.
REQ-017 req_ready[i] SHALL equal k_arg0_ready when i is the current grant, else 0; never two bits set.
REQ-018 On each argument transfer rr_ptr SHALL become (grant+1) mod N_REQ.
REQ-019 A requester SHALL hold req_valid and req_data stable until accepted; arbiter SHALL NOT change grant while in LOCK.
REQ-020 Fifo full (inflight=DEPTH): k_arg0_valid=0 in IDLE, no grant; no same-cycle push-on-pop bypass.
REQ-021 Fifo full cannot occur in LOCK (entry to LOCK already checked space, no push in between).
REQ-022 rsp_data SHALL equal k_out0; rsp_valid[head tag]=k_out0_valid when fifo non-empty, all other rsp_valid 0.
REQ-023 k_out0_ready SHALL equal rsp_ready[head tag] when fifo non-empty, else 0.
REQ-024 Simultaneous push and pop SHALL leave inflight unchanged and both entries correct.
REQ-025 k_out0_valid=1 with empty fifo SHALL set err=1 (sticky until reset); result not accepted.
REQ-026 inflight SHALL be registered count of fifo entries, range 0..DEPTH, no wrap.
REQ-027 Latency: argument request to kernel = 0 cycles; kernel result to requester = 0 cycles (combinational routing, no data registering).

Reset
REQ-028 While rst=0, asynchronously: FSM=IDLE, rr_ptr=0, fifo empty, inflight=0, err=0.
REQ-029 During reset all of req_ready, rsp_valid, k_arg0_valid, k_out0_ready SHALL be 0; k_arg0 and rsp_data don't-care.
REQ-030 Reset asserted mid-transaction SHALL discard in-flight tags and locked grant; no response routed after release for pre-reset arguments.
REQ-031 First arbitration after reset release SHALL occur on the first rising edge with rst=1.

Verification
REQ-032 All 4 req_valid=1, data 10+i, kernel always ready, identity kernel latency 3 -> issue order 0,1,2,3,0; each requester receives its own value 10+i.
REQ-033 Requester 2 valid, k_arg0_ready low 5 cycles while requester 0 becomes valid -> LOCK holds grant 2, k_arg0 stays 12, req_ready[0]=0 throughout; 2 transfers, then 0.
REQ-034 Kernel stalled (k_out0_valid=0), continuous requests -> exactly 4 issues, inflight=4, k_arg0_valid=0 until first result popped.
REQ-035 Head tag=1, rsp_ready[1]=0 for 3 cycles while rsp_ready others=1 -> k_out0_ready=0 for 3 cycles, no other rsp_valid asserted; result then delivered to 1.
REQ-036 Push and pop same cycle at inflight=2 -> inflight stays 2; k_out0_valid with inflight=0 -> err=1 persisting until rst=0.
REQ-037 rst pulsed low with inflight=3 in LOCK -> all outputs 0 immediately, inflight=0, next grant from index 0.

Source files
------------

// File: rtl/kernel_share_arbiter.sv
// rtl/kernel_share_arbiter.sv - round-robin sharing of one in-order kernel among N_REQ requesters
//
// Ports:
//   clk            single clock, all state on the rising edge
//   rst            asynchronous active-low reset
//   req_data       N_REQ*DATA_W argument data, slice i belongs to requester i
//   req_valid      per-requester argument valid
//   req_ready      per-requester argument ready (at most one bit set)
//   rsp_data       shared result data (mirror of k_out0)
//   rsp_valid      per-requester result valid (only the head-tag owner)
//   rsp_ready      per-requester result ready
//   k_arg0         kernel argument data
//   k_arg0_valid   kernel argument valid
//   k_arg0_ready   kernel argument ready
//   k_out0         kernel result data
//   k_out0_valid   kernel result valid
//   k_out0_ready   kernel result ready
//   inflight       number of issued arguments whose results are still outstanding
//   err            sticky: kernel produced a result with nothing outstanding
module kernel_share_arbiter #(
  parameter int DATA_W = 10,
  parameter int N_REQ  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic [DATA_W-1:0]          k_arg0,
  output logic                       k_arg0_valid,
  input  logic                       k_arg0_ready,
  input  logic [DATA_W-1:0]          k_out0,
  input  logic                       k_out0_valid,
  output logic                       k_out0_ready,
  output logic [$clog2(DEPTH+1)-1:0] inflight,
  output logic                       err
);

  localparam int TAG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state, state_nxt;
  logic [TAG_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   lock_grant;

  logic [TAG_W-1:0]   tag_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               fifo_full, fifo_empty;
  logic [TAG_W-1:0]   head_tag;

  logic               any_valid;
  logic [TAG_W-1:0]   rr_sel;
  logic               grant_valid;
  logic [TAG_W-1:0]   grant;
  logic               push, pop;
  logic               head_ready;

  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);
  assign head_tag   = tag_mem[rd_ptr];

  // Round-robin search: walk downward over the distance from rr_ptr so the
  // last hit is the nearest valid requester at or above rr_ptr (with wrap).
  always_comb begin
    int idx;
    any_valid = 1'b0;
    rr_sel    = '0;
    idx       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx]) begin
        any_valid = 1'b1;
        rr_sel    = TAG_W'(idx);
      end
    end
  end

  // Grant selection and FSM next state. In LOCK the registered grant is
  // reused verbatim so a stalled argument can never be re-arbitrated away.
  always_comb begin
    state_nxt   = state;
    grant_valid = 1'b0;
    grant       = rr_sel;
    case (state)
      IDLE: begin
        if (!fifo_full && any_valid) begin
          grant_valid = 1'b1;
          grant       = rr_sel;
          if (!k_arg0_ready) state_nxt = LOCK;
        end
      end
      LOCK: begin
        grant_valid = 1'b1;
        grant       = lock_grant;
        if (k_arg0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are gated by rst so nothing is offered while reset is held,
  // even though requesters may keep their valids asserted.
  assign k_arg0_valid = grant_valid & rst;
  assign k_arg0       = req_data[int'(grant)*DATA_W +: DATA_W];

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = k_arg0_valid && k_arg0_ready && (grant == TAG_W'(i));
    end
  end

  always_comb begin
    head_ready = 1'b0;
    rsp_valid  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (head_tag == TAG_W'(i)) begin
        head_ready   = rsp_ready[i];
        rsp_valid[i] = k_out0_valid && !fifo_empty && rst;
      end
    end
  end

  assign rsp_data     = k_out0;
  assign k_out0_ready = head_ready && !fifo_empty && rst;

  assign push = k_arg0_valid && k_arg0_ready;
  assign pop  = k_out0_valid && k_out0_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      lock_grant <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == LOCK) lock_grant <= grant;
      if (push) begin
        rr_ptr <= (grant == TAG_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // Full blocks push in IDLE and empty blocks pop, so count stays in 0..DEPTH.
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (k_out0_valid && fifo_empty) err <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end

  assign inflight = count;

endmodule

// File: tb/tb_kernel_share_arbiter.sv
// tb/tb_kernel_share_arbiter.sv - directed self-checking bench for kernel_share_arbiter
module tb_kernel_share_arbiter;

  localparam int DATA_W = 10;
  localparam int N_REQ  = 4;
  localparam int DEPTH  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]       rsp_data;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]       k_arg0;
  logic                    k_arg0_valid;
  logic                    k_arg0_ready;
  logic [DATA_W-1:0]       k_out0;
  logic                    k_out0_valid;
  logic                    k_out0_ready;
  logic [2:0]              inflight;
  logic                    err;

  int n_asserts = 0;
  int n_fail    = 0;

  kernel_share_arbiter #(.DATA_W(DATA_W), .N_REQ(N_REQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .k_arg0(k_arg0), .k_arg0_valid(k_arg0_valid), .k_arg0_ready(k_arg0_ready),
    .k_out0(k_out0), .k_out0_valid(k_out0_valid), .k_out0_ready(k_out0_ready),
    .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Argument issue check: valid, data and the one-hot ready of the granted requester.
  task automatic chk_issue(input string tag, input logic [31:0] data, input logic [31:0] rdy);
    #1;
    chk({tag, ".valid"}, 32'(k_arg0_valid), 32'd1);
    chk({tag, ".arg"}, 32'(k_arg0), data);
    chk({tag, ".req_ready"}, 32'(req_ready), rdy);
  endtask

  // Result routing check with k_out0_valid=1.
  task automatic chk_rsp(input string tag, input logic [31:0] data, input logic [31:0] vld,
                         input logic [31:0] krdy);
    #1;
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), vld);
    chk({tag, ".rsp_data"}, 32'(rsp_data), data);
    chk({tag, ".k_out0_ready"}, 32'(k_out0_ready), krdy);
  endtask

  initial begin
    rst          = 1'b1;
    req_data     = {10'd13, 10'd12, 10'd11, 10'd10};
    req_valid    = 4'hF;
    rsp_ready    = 4'hF;
    k_arg0_ready = 1'b1;
    k_out0       = '0;
    k_out0_valid = 1'b0;
    #2 rst = 1'b0;

    // Reset: outputs quiet even with requests and kernel ready present.
    tick();
    #1;
    chk("rst.k_arg0_valid", 32'(k_arg0_valid), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.k_out0_ready", 32'(k_out0_ready), 32'd0);
    chk("rst.inflight", 32'(inflight), 32'd0);
    chk("rst.err", 32'(err), 32'd0);

    // All four requesting, kernel ready, kernel stalled on results: issue 0,1,2,3 then full.
    rst = 1'b1;
    chk_issue("rr0", 32'd10, 32'h1);
    tick();
    chk("rr0.inflight", 32'(inflight), 32'd1);
    chk_issue("rr1", 32'd11, 32'h2);
    tick();
    chk_issue("rr2", 32'd12, 32'h4);
    tick();
    chk_issue("rr3", 32'd13, 32'h8);
    tick();
    #1;
    chk("full.inflight", 32'(inflight), 32'd4);
    chk("full.k_arg0_valid", 32'(k_arg0_valid), 32'd0);
    chk("full.req_ready", 32'(req_ready), 32'd0);
    tick();
    #1;
    chk("full2.inflight", 32'(inflight), 32'd4);
    chk("full2.k_arg0_valid", 32'(k_arg0_valid), 32'd0);

    // Results return in issue order, each routed to its own requester.
    req_valid    = 4'h0;
    k_out0       = 10'd10;
    k_out0_valid = 1'b1;
    chk_rsp("pop0", 32'd10, 32'h1, 32'd1);
    tick();
    chk("pop0.inflight", 32'(inflight), 32'd3);
    k_out0 = 10'd11;
    chk_rsp("pop1", 32'd11, 32'h2, 32'd1);
    tick();
    chk("pop1.inflight", 32'(inflight), 32'd2);

    // Push and pop together at inflight=2; fifth issue goes back to requester 0.
    req_valid = 4'h1;
    k_out0    = 10'd12;
    chk_rsp("pp.pop2", 32'd12, 32'h4, 32'd1);
    chk_issue("rr4", 32'd10, 32'h1);
    tick();
    chk("pp.inflight", 32'(inflight), 32'd2);
    req_valid = 4'h0;
    k_out0    = 10'd13;
    chk_rsp("pop3", 32'd13, 32'h8, 32'd1);
    tick();
    k_out0 = 10'd10;
    chk_rsp("pop0b", 32'd10, 32'h1, 32'd1);
    tick();
    chk("drain.inflight", 32'(inflight), 32'd0);
    k_out0_valid = 1'b0;

    // Head tag 1 with its requester not ready: result held, nobody else sees it.
    req_valid = 4'h2;
    chk_issue("iss1", 32'd11, 32'h2);
    tick();
    req_valid    = 4'h0;
    k_out0       = 10'd11;
    k_out0_valid = 1'b1;
    rsp_ready    = 4'b1101;
    for (int c = 0; c < 3; c++) begin
      chk_rsp("hold1", 32'd11, 32'h2, 32'd0);
      tick();
      chk("hold1.inflight", 32'(inflight), 32'd1);
    end
    rsp_ready = 4'hF;
    chk_rsp("deliver1", 32'd11, 32'h2, 32'd1);
    tick();
    chk("deliver1.inflight", 32'(inflight), 32'd0);
    k_out0_valid = 1'b0;

    // Move rr_ptr to 3 so an unlocked re-arbitration would favour requester 0 over 2.
    req_valid = 4'h4;
    chk_issue("iss2", 32'd12, 32'h4);
    tick();
    k_arg0_ready = 1'b0;
    chk_issue("lock.enter", 32'd12, 32'h0);
    tick();
    req_valid = 4'h5;
    for (int c = 0; c < 5; c++) begin
      chk_issue("lock.hold", 32'd12, 32'h0);
      tick();
    end
    k_arg0_ready = 1'b1;
    chk_issue("lock.xfer", 32'd12, 32'h4);
    tick();
    chk("lock.inflight", 32'(inflight), 32'd2);
    req_valid = 4'h1;
    chk_issue("after.lock", 32'd10, 32'h1);
    tick();
    chk("after.inflight", 32'(inflight), 32'd3);

    // Requester 1 locked with three in flight, then reset mid-transaction.
    req_valid    = 4'h2;
    k_arg0_ready = 1'b0;
    chk_issue("lock1", 32'd11, 32'h0);
    tick();
    k_arg0_ready = 1'b1;
    k_out0_valid = 1'b1;
    rst          = 1'b0;
    #1;
    chk("mrst.k_arg0_valid", 32'(k_arg0_valid), 32'd0);
    chk("mrst.req_ready", 32'(req_ready), 32'd0);
    chk("mrst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst.k_out0_ready", 32'(k_out0_ready), 32'd0);
    chk("mrst.inflight", 32'(inflight), 32'd0);
    chk("mrst.err", 32'(err), 32'd0);
    k_out0_valid = 1'b0;
    tick();
    rst       = 1'b1;
    req_valid = 4'hF;
    chk_issue("post.grant0", 32'd10, 32'h1);

    // Stale kernel result after reset: not routed, err becomes sticky.
    req_valid    = 4'h0;
    k_out0_valid = 1'b1;
    #1;
    chk("stale.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stale.k_out0_ready", 32'(k_out0_ready), 32'd0);
    tick();
    chk("stale.err", 32'(err), 32'd1);
    chk("stale.inflight", 32'(inflight), 32'd0);
    k_out0_valid = 1'b0;
    tick();
    tick();
    chk("sticky.err", 32'(err), 32'd1);
    rst = 1'b0;
    #1;
    chk("clr.err", 32'(err), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
